// File: rtl/slice_fetch_scheduler.sv
// slice_fetch_scheduler
// Turns turn-timer row changes into per-row slice fetches from the front
// frame-buffer bank and streams the words to the LED driver (ready/valid).
// Owns front/back bank swapping, which happens only at a row-0 start so a
// displayed frame is never torn. A row change that lands mid-fetch aborts
// the fetch and is counted as a miss.
module slice_fetch_scheduler #(
    parameter int IMG_HEIGHT    = 1024,
    parameter int WORDS_PER_ROW = 16,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 24,
    parameter int BANK_STRIDE   = 'h10000,
    localparam int RW           = $clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RW-1:0]     row,
    input  logic              valid,
    input  logic              rowChange,
    input  logic              swapReq,
    output logic              swapAck,
    output logic              frontBank,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic              memRdValid,
    input  logic [DATA_W-1:0] memRdData,
    output logic [DATA_W-1:0] ledData,
    output logic              ledValid,
    input  logic              ledReady,
    output logic              ledFirst,
    output logic              ledLast,
    output logic              ledBlank,
    output logic              overrun,
    output logic [15:0]       missCount
);

    localparam int WW = $clog2(WORDS_PER_ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_RESTART
    } state_t;

    state_t            state, state_nx;
    logic [RW-1:0]     cur_row, cur_row_nx;
    logic [RW-1:0]     pend_row, pend_row_nx;
    logic [WW-1:0]     word, word_nx;
    logic              bank, bank_nx;
    logic              swap_ack_nx;
    logic              abort_pend, abort_pend_nx;  // in-flight read must be discarded
    logic              late_start, late_start_nx;  // row change that coincided with completion
    logic [DATA_W-1:0] data_q, data_nx;
    logic              ovr_nx;
    logic              start_go;
    logic [RW-1:0]     start_row;
    logic              row_evt;
    logic              last_word;
    logic              done_now;
    logic [ADDR_W-1:0] bank_off;

    assign row_evt   = rowChange && valid;
    assign last_word = &word;
    assign done_now  = (state == S_PUSH) && ledReady && last_word;

    // Bank base plus {row, word}; WORDS_PER_ROW is a power of two so the
    // concatenation is row*WORDS_PER_ROW + word.
    assign bank_off = bank ? ADDR_W'(BANK_STRIDE) : '0;
    assign memAddr  = bank_off + ADDR_W'({cur_row, word});

    assign memReq    = (state == S_REQ);
    assign ledValid  = (state == S_PUSH);
    assign ledFirst  = (state == S_PUSH) && (word == '0);
    assign ledLast   = (state == S_PUSH) && last_word;
    assign ledData   = data_q;
    assign frontBank = bank;

    // Next-state, abort bookkeeping and fetch start (with optional bank swap).
    always_comb begin
        state_nx      = state;
        cur_row_nx    = cur_row;
        pend_row_nx   = pend_row;
        word_nx       = word;
        bank_nx       = bank;
        swap_ack_nx   = 1'b0;
        abort_pend_nx = abort_pend;
        late_start_nx = late_start;
        data_nx       = data_q;
        ovr_nx        = 1'b0;
        start_go      = 1'b0;
        start_row     = row;

        // A row change while busy aborts, unless the last word leaves this cycle.
        if (row_evt && (state != S_IDLE) && !done_now) begin
            ovr_nx      = 1'b1;
            pend_row_nx = row;
            if ((state == S_REQ) || (state == S_WAIT))
                abort_pend_nx = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (row_evt) begin
                    start_go      = 1'b1;
                    start_row     = row;
                    late_start_nx = 1'b0;
                end else if (late_start) begin
                    start_go      = 1'b1;
                    start_row     = pend_row;
                    late_start_nx = 1'b0;
                end
            end
            S_REQ: begin
                // memReq stays up until accepted, even when aborted.
                if (memAck)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (memRdValid) begin
                    if (abort_pend || row_evt) begin
                        abort_pend_nx = 1'b0;
                        state_nx      = S_RESTART;
                    end else begin
                        data_nx  = memRdData;
                        state_nx = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (done_now) begin
                    state_nx = S_IDLE;
                    if (row_evt) begin
                        late_start_nx = 1'b1;
                        pend_row_nx   = row;
                    end
                end else if (row_evt) begin
                    state_nx = S_RESTART;
                end else if (ledReady) begin
                    word_nx  = word + 1'b1;
                    state_nx = S_REQ;
                end
            end
            S_RESTART: begin
                start_go  = 1'b1;
                start_row = row_evt ? row : pend_row;
            end
            default: state_nx = S_IDLE;
        endcase

        if (start_go) begin
            cur_row_nx = start_row;
            word_nx    = '0;
            state_nx   = S_REQ;
            if ((start_row == '0) && swapReq) begin
                bank_nx     = ~bank;
                swap_ack_nx = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_row    <= '0;
            pend_row   <= '0;
            word       <= '0;
            bank       <= 1'b0;
            swapAck    <= 1'b0;
            abort_pend <= 1'b0;
            late_start <= 1'b0;
            data_q     <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_row    <= cur_row_nx;
            pend_row   <= pend_row_nx;
            word       <= word_nx;
            bank       <= bank_nx;
            swapAck    <= swap_ack_nx;
            abort_pend <= abort_pend_nx;
            late_start <= late_start_nx;
            data_q     <= data_nx;
            overrun    <= ovr_nx;
        end
    end

    // Saturating miss counter.
    always_ff @(posedge clk) begin
        if (reset)
            missCount <= '0;
        else if (ovr_nx && (missCount != 16'hFFFF))
            missCount <= missCount + 16'd1;
    end

    // Blank the LEDs one cycle after the turn timer loses lock.
    always_ff @(posedge clk) begin
        if (reset)
            ledBlank <= 1'b1;
        else
            ledBlank <= !valid;
    end

endmodule

// File: tb/tb_slice_fetch_scheduler.sv
// Directed bench for slice_fetch_scheduler: table of full fetches plus
// hand-written abort, completion-race, blanking and saturation sequences.
module tb_slice_fetch_scheduler;

    localparam int RW     = 10;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic [RW-1:0]     row;
    logic              valid;
    logic              rowChange;
    logic              swapReq;
    logic              swapAck;
    logic              frontBank;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memAck;
    logic              memRdValid;
    logic [DATA_W-1:0] memRdData;
    logic [DATA_W-1:0] ledData;
    logic              ledValid;
    logic              ledReady;
    logic              ledFirst;
    logic              ledLast;
    logic              ledBlank;
    logic              overrun;
    logic [15:0]       missCount;

    slice_fetch_scheduler dut (
        .clk(clk), .reset(reset), .row(row), .valid(valid), .rowChange(rowChange),
        .swapReq(swapReq), .swapAck(swapAck), .frontBank(frontBank),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memRdValid(memRdValid),
        .memRdData(memRdData), .ledData(ledData), .ledValid(ledValid), .ledReady(ledReady),
        .ledFirst(ledFirst), .ledLast(ledLast), .ledBlank(ledBlank),
        .overrun(overrun), .missCount(missCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
    } led_t;

    typedef struct {
        logic [RW-1:0]     row;
        logic              swap;
        int                dly;
        logic              exp_bank;
        int                exp_swp;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    logic [ADDR_W-1:0] acc_q[$];
    led_t              led_q[$];
    int                swp_n = 0;
    int                ovr_n = 0;
    int                ack_delay = 0;
    int                total = 0;
    int                bad = 0;

    // Memory model: ack after ack_delay cycles of memReq, data one cycle later.
    logic [DATA_W-1:0] rd_data;
    logic              rd_due;
    int                req_wait;
    initial begin
        memAck = 1'b0; memRdValid = 1'b0; memRdData = '0;
        rd_due = 1'b0; rd_data = '0; req_wait = 0;
        forever begin
            @(posedge clk); #1;
            memAck = 1'b0; memRdValid = 1'b0;
            if (rd_due) begin
                memRdValid = 1'b1; memRdData = rd_data; rd_due = 1'b0;
            end
            if (memReq) begin
                if (req_wait >= ack_delay) begin
                    memAck = 1'b1; rd_data = {8'hD0, memAddr}; rd_due = 1'b1; req_wait = 0;
                end else begin
                    req_wait++;
                end
            end else begin
                req_wait = 0;
            end
        end
    end

    // Handshake / pulse recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (memReq && memAck) acc_q.push_back(memAddr);
            if (ledValid && ledReady) led_q.push_back('{ledData, ledFirst, ledLast});
            if (overrun) ovr_n++;
            if (swapAck) swp_n++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_row(input logic [RW-1:0] r);
        row = r; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
    endtask

    task automatic wait_words(input string nm, input int l0, input int n, input int limit);
        int k;
        k = 0;
        while ((led_q.size() < l0 + n) && (k < limit)) begin
            tick();
            k++;
        end
        chk(nm, (led_q.size() >= l0 + n), 1);
    endtask

    task automatic check_words(input string nm, input int l0, input logic [ADDR_W-1:0] base);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 16; i++) begin
            if (l0 + i >= led_q.size()) nbad++;
            else if (led_q[l0+i].data !== {8'hD0, base + ADDR_W'(i)} ||
                     led_q[l0+i].first !== (i == 0) || led_q[l0+i].last !== (i == 15))
                nbad++;
        end
        chk(nm, nbad, 0);
    endtask

    function automatic logic [ADDR_W-1:0] acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 'x;
    endfunction

    vec_t vt[8];
    int   a0, l0, s0, o0, nreq, drop, guard;
    logic [15:0] m0;

    initial begin
        vt[0] = '{10'd5,    1'b0, 0, 1'b0, 0, 24'h000050};
        vt[1] = '{10'd0,    1'b1, 0, 1'b1, 1, 24'h010000};
        vt[2] = '{10'd7,    1'b1, 0, 1'b1, 0, 24'h010070};
        vt[3] = '{10'd0,    1'b1, 2, 1'b0, 1, 24'h000000};
        vt[4] = '{10'd0,    1'b0, 0, 1'b0, 0, 24'h000000};
        vt[5] = '{10'd1023, 1'b0, 1, 1'b0, 0, 24'h003FF0};
        vt[6] = '{10'd0,    1'b1, 0, 1'b1, 1, 24'h010000};
        vt[7] = '{10'd0,    1'b1, 0, 1'b0, 1, 24'h000000};

        reset = 1'b1; valid = 1'b1; rowChange = 1'b0; row = '0;
        swapReq = 1'b0; ledReady = 1'b1;
        repeat (3) tick();
        chk("rst_memReq", memReq, 0);
        chk("rst_ledValid", ledValid, 0);
        chk("rst_ledBlank", ledBlank, 1);
        chk("rst_frontBank", frontBank, 0);
        chk("rst_missCount", missCount, 0);
        chk("rst_pulses", {swapAck, overrun}, 0);
        reset = 1'b0;
        tick();
        chk("ledBlank_after_rst", ledBlank, 0);

        // Full fetches: address, bank swap rule, word stream flags.
        for (int i = 0; i < 8; i++) begin
            ack_delay = vt[i].dly; swapReq = vt[i].swap;
            a0 = acc_q.size(); l0 = led_q.size(); s0 = swp_n; o0 = ovr_n;
            start_row(vt[i].row);
            wait_words("v_done", l0, 16, 400);
            swapReq = 1'b0;
            chk("v_bank", frontBank, vt[i].exp_bank);
            chk("v_swapAck", swp_n - s0, vt[i].exp_swp);
            chk("v_addr0", acc_at(a0), vt[i].exp_addr);
            chk("v_addr15", acc_at(a0 + 15), vt[i].exp_addr + 24'd15);
            chk("v_nreads", acc_q.size() - a0, 16);
            check_words("v_words", l0, vt[i].exp_addr);
            chk("v_no_overrun", ovr_n - o0, 0);
            tick(); tick();
        end
        chk("v_missCount", missCount, 0);

        // Abort while a word is stalled on ledReady.
        ack_delay = 0; ledReady = 1'b0; o0 = ovr_n;
        start_row(10'd3);
        guard = 0;
        while (!ledValid && guard < 50) begin tick(); guard++; end
        chk("a_ledValid", ledValid, 1);
        tick(); tick();
        row = 10'd9; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
        a0 = acc_q.size(); l0 = led_q.size();
        chk("a_overrun", overrun, 1);
        chk("a_ledValid_drop", ledValid, 0);
        chk("a_missCount", missCount, 1);
        tick();
        chk("a_overrun_pulse", overrun, 0);
        chk("a_memReq", memReq, 1);
        chk("a_memAddr", memAddr, 24'd144);
        ledReady = 1'b1;
        wait_words("a_done", l0, 16, 400);
        check_words("a_words", l0, 24'd144);
        chk("a_n_overrun", ovr_n - o0, 1);

        // Abort while memReq waits for a stalled ack.
        tick();
        ack_delay = 5;
        start_row(10'd4);
        chk("b_memReq", memReq, 1);
        chk("b_memAddr", memAddr, 24'd64);
        a0 = acc_q.size(); l0 = led_q.size();
        row = 10'd11; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
        chk("b_overrun", overrun, 1);
        chk("b_missCount", missCount, 2);
        drop = 0; guard = 0;
        while (acc_q.size() == a0 && guard < 20) begin
            if (!(memReq && memAddr == 24'd64)) drop++;
            tick(); guard++;
        end
        chk("b_req_held", drop, 0);
        chk("b_acked_addr", acc_at(a0), 24'd64);
        wait_words("b_done", l0, 16, 600);
        chk("b_next_addr", acc_at(a0 + 1), 24'd176);
        check_words("b_words", l0, 24'd176);

        // Row change on the same cycle the last word is accepted.
        tick();
        ack_delay = 0; ledReady = 1'b0; o0 = ovr_n; m0 = missCount;
        start_row(10'd1);
        guard = 0;
        while (!(ledValid && ledLast) && guard < 300) begin
            ledReady = ledValid;
            tick(); guard++;
        end
        chk("d_last_held", ledValid && ledLast, 1);
        l0 = led_q.size();
        ledReady = 1'b1; row = 10'd12; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
        chk("d_no_overrun", overrun, 0);
        chk("d_idle", ledValid | memReq, 0);
        chk("d_last_taken", led_q.size() - l0, 1);
        tick();
        chk("d_memReq", memReq, 1);
        chk("d_memAddr", memAddr, 24'd192);
        chk("d_missCount", missCount, m0);
        l0 = led_q.size();
        wait_words("d_done", l0, 16, 400);
        check_words("d_words", l0, 24'd192);
        chk("d_n_overrun", ovr_n - o0, 0);

        // Lost lock: blanking, ignored row changes, recovery.
        tick();
        valid = 1'b0;
        tick();
        chk("c_blank", ledBlank, 1);
        row = 10'd2; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
        nreq = 0;
        repeat (5) begin
            if (memReq) nreq++;
            tick();
        end
        chk("c_no_req", nreq, 0);
        valid = 1'b1;
        tick();
        chk("c_unblank", ledBlank, 0);
        a0 = acc_q.size(); l0 = led_q.size();
        start_row(10'd2);
        wait_words("c_done", l0, 16, 400);
        chk("c_addr0", acc_at(a0), 24'd32);
        check_words("c_words", l0, 24'd32);

        // Lock lost mid-fetch: fetch still completes, row change ignored.
        tick();
        ack_delay = 2; o0 = ovr_n; l0 = led_q.size();
        start_row(10'd6);
        tick(); tick(); tick();
        valid = 1'b0; row = 10'd8; rowChange = 1'b1;
        tick();
        rowChange = 1'b0;
        wait_words("c_vdrop_done", l0, 16, 400);
        check_words("c_vdrop_words", l0, 24'd96);
        chk("c_vdrop_overrun", ovr_n - o0, 0);
        valid = 1'b1;
        tick(); tick();

        // Miss counter saturation, then reset in the middle of a fetch.
        ack_delay = 1000000; swapReq = 1'b1;
        start_row(10'd0);
        swapReq = 1'b0;
        tick();
        chk("e_bank", frontBank, 1);
        row = 10'd5; rowChange = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        rowChange = 1'b0;
        chk("e_saturate", missCount, 16'hFFFF);
        chk("e_memReq", memReq, 1);
        reset = 1'b1;
        tick();
        chk("e_rst_memReq", memReq, 0);
        chk("e_rst_bank", frontBank, 0);
        chk("e_rst_miss", missCount, 0);
        chk("e_rst_blank", ledBlank, 1);
        reset = 1'b0; ack_delay = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
